// File: rtl/lpm_memory_arbiter.sv
// lpm_memory_arbiter: round-robin sharing of one single-outstanding LpmMemory
// between NREQ lookup clients. Each client has a one-entry request buffer; the
// arbiter issues one buffered request at a time, remembers its owner, and
// steers the response handshake back to that owner only.
`timescale 1ns/1ps

module lpm_memory_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 96,
    parameter int IDXW  = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       cli_req_ENA,
    input  logic [NREQ*WIDTH-1:0] cli_req_v,
    output logic [NREQ-1:0]       cli_req_RDY,
    output logic [WIDTH-1:0]      cli_resValue,
    output logic [NREQ-1:0]       cli_resValue_RDY,
    input  logic [NREQ-1:0]       cli_resAccept_ENA,
    output logic [NREQ-1:0]       cli_resAccept_RDY,
    output logic                  mem_req_ENA,
    output logic [WIDTH-1:0]      mem_req_v,
    input  logic                  mem_req_RDY,
    input  logic [WIDTH-1:0]      mem_resValue,
    input  logic                  mem_resValue_RDY,
    output logic                  mem_resAccept_ENA,
    input  logic                  mem_resAccept_RDY
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

    // Arbiter state
    logic [NREQ-1:0]  r_pending;
    logic [WIDTH-1:0] r_buf [NREQ];
    state_t           r_state;
    logic [IDXW-1:0]  r_owner;
    logic [IDXW-1:0]  r_rr_ptr;

    // Combinational decisions
    logic [IDXW-1:0]  w_scan;
    logic [IDXW-1:0]  w_winner;
    logic             w_found;
    logic [IDXW-1:0]  w_next_ptr;
    logic             w_issue;
    logic             w_accept;
    logic             w_busy;
    logic [NREQ-1:0]  w_owner_hot;

    // Round-robin search: first pending client starting at r_rr_ptr, wrapping at NREQ
    always_comb begin
        w_scan   = r_rr_ptr;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && r_pending[w_scan]) begin
                w_winner = w_scan;
                w_found  = 1'b1;
            end
            w_scan = (w_scan == LAST_IDX) ? '0 : w_scan + 1'b1;
        end
    end

    // The pointer moves just past the winner; explicit wrap covers non-power-of-2 NREQ
    assign w_next_ptr = (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;

    assign w_busy      = (r_state == S_BUSY);
    assign w_issue     = (r_state == S_IDLE) && w_found && mem_req_RDY;
    assign w_owner_hot = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    // Only the owner's accept can retire the in-flight response
    assign w_accept    = w_busy && cli_resAccept_ENA[r_owner] && mem_resAccept_RDY;

    // Memory-side request and response handshake
    assign mem_req_ENA       = w_issue;
    assign mem_req_v         = w_issue ? r_buf[w_winner] : '0;
    assign mem_resAccept_ENA = w_accept;

    // Client-side handshake: response bits are steered to the owner only
    assign cli_req_RDY       = ~r_pending;
    assign cli_resValue      = mem_resValue;
    assign cli_resValue_RDY  = (w_busy && mem_resValue_RDY)  ? w_owner_hot : '0;
    assign cli_resAccept_RDY = (w_busy && mem_resAccept_RDY) ? w_owner_hot : '0;

    // Request buffers: capture on a client strobe, drain when that client wins an issue
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_pending <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                // A full buffer ignores the strobe, so capture and drain never coincide
                if (cli_req_ENA[i] && !r_pending[i]) begin
                    r_pending[i] <= 1'b1;
                    r_buf[i]     <= cli_req_v[i*WIDTH +: WIDTH];
                end else if (w_issue && (w_winner == IDXW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Issue/response FSM with owner and round-robin pointer tracking
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_owner  <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Returning to IDLE here means the next issue is at least one cycle later
                    if (w_accept) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpm_memory_arbiter.sv
// Directed testbench for lpm_memory_arbiter with a small 4-cycle memory model.
`timescale 1ns/1ps

module tb_lpm_memory_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 96;

    logic              CLK;
    logic              nRST;
    logic [NREQ-1:0]   cli_req_ENA;
    logic [NREQ*W-1:0] cli_req_v;
    logic [NREQ-1:0]   cli_req_RDY;
    logic [W-1:0]      cli_resValue;
    logic [NREQ-1:0]   cli_resValue_RDY;
    logic [NREQ-1:0]   cli_resAccept_ENA;
    logic [NREQ-1:0]   cli_resAccept_RDY;
    logic              mem_req_ENA;
    logic [W-1:0]      mem_req_v;
    logic              mem_req_RDY;
    logic [W-1:0]      mem_resValue;
    logic              mem_resValue_RDY;
    logic              mem_resAccept_ENA;
    logic              mem_resAccept_RDY;

    int n_chk  = 0;
    int n_fail = 0;

    lpm_memory_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .cli_req_ENA       (cli_req_ENA),
        .cli_req_v         (cli_req_v),
        .cli_req_RDY       (cli_req_RDY),
        .cli_resValue      (cli_resValue),
        .cli_resValue_RDY  (cli_resValue_RDY),
        .cli_resAccept_ENA (cli_resAccept_ENA),
        .cli_resAccept_RDY (cli_resAccept_RDY),
        .mem_req_ENA       (mem_req_ENA),
        .mem_req_v         (mem_req_v),
        .mem_req_RDY       (mem_req_RDY),
        .mem_resValue      (mem_resValue),
        .mem_resValue_RDY  (mem_resValue_RDY),
        .mem_resAccept_ENA (mem_resAccept_ENA),
        .mem_resAccept_RDY (mem_resAccept_RDY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: count 4 after a request, down to 1, respond at 1 until accepted
    logic [2:0]   m_cnt;
    logic [W-1:0] m_data;

    always @(posedge CLK) begin
        if (!nRST) begin
            m_cnt  <= 3'd0;
            m_data <= '0;
        end else if (mem_req_ENA && m_cnt == 3'd0) begin
            m_cnt  <= 3'd4;
            m_data <= mem_req_v;
        end else if (m_cnt > 3'd1) begin
            m_cnt <= m_cnt - 3'd1;
        end else if (m_cnt == 3'd1 && mem_resAccept_ENA) begin
            m_cnt <= 3'd0;
        end
    end

    assign mem_req_RDY       = (m_cnt == 3'd0);
    assign mem_resValue_RDY  = (m_cnt == 3'd1);
    assign mem_resAccept_RDY = (m_cnt == 3'd1);
    assign mem_resValue      = m_data + 96'd1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge
    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_v(input int i, input logic [W-1:0] v);
        cli_req_v[i*W +: W] = v;
    endtask

    task automatic do_reset();
        nRST              = 1'b0;
        cli_req_ENA       = '0;
        cli_resAccept_ENA = '0;
        adv();
        adv();
        nRST = 1'b1;
    endtask

    localparam logic [W-1:0] PAY_A = 96'h0000000C_0000000B_0000000A;

    int grants;
    int per_cli [NREQ];

    initial begin
        nRST              = 1'b0;
        cli_req_ENA       = '0;
        cli_req_v         = '0;
        cli_resAccept_ENA = '0;

        // Reset state
        adv();
        settle();
        chk("rst_req_rdy",    cli_req_RDY,       4'hF);
        chk("rst_mem_req",    mem_req_ENA,       1'b0);
        chk("rst_mem_req_v",  mem_req_v,         '0);
        chk("rst_res_rdy",    cli_resValue_RDY,  4'h0);
        chk("rst_acc_rdy",    cli_resAccept_RDY, 4'h0);
        chk("rst_mem_acc",    mem_resAccept_ENA, 1'b0);
        adv();
        nRST = 1'b1;

        // Single request from client 2 (cycle 0)
        set_v(2, PAY_A);
        cli_req_ENA = 4'b0100;
        settle();
        chk("t1_c0_req_rdy", cli_req_RDY, 4'hF);
        adv();                       // cycle 1
        cli_req_ENA = '0;
        settle();
        chk("t1_c1_issue",   mem_req_ENA, 1'b1);
        chk("t1_c1_payload", mem_req_v,   PAY_A);
        chk("t1_c1_req_rdy", cli_req_RDY, 4'b1011);
        adv();                       // cycle 2
        settle();
        chk("t1_c2_req_rdy", cli_req_RDY, 4'hF);
        chk("t1_c2_no_issue", mem_req_ENA, 1'b0);
        chk("t1_c2_res_rdy", cli_resValue_RDY, 4'h0);
        adv();                       // cycle 3
        adv();                       // cycle 4
        settle();
        chk("t1_c4_res_rdy", cli_resValue_RDY, 4'h0);
        adv();                       // cycle 5
        settle();
        chk("t1_c5_res_rdy", cli_resValue_RDY,  4'b0100);
        chk("t1_c5_acc_rdy", cli_resAccept_RDY, 4'b0100);
        chk("t1_c5_res_val", cli_resValue, 96'h0000000C_0000000B_0000000B);
        cli_resAccept_ENA = 4'b0100;
        settle();
        chk("t1_c5_mem_acc", mem_resAccept_ENA, 1'b1);
        adv();                       // cycle 6
        cli_resAccept_ENA = '0;
        settle();
        chk("t1_c6_res_rdy", cli_resValue_RDY,  4'h0);
        chk("t1_c6_acc_rdy", cli_resAccept_RDY, 4'h0);

        // Contention: clients 0 and 3 together, rr_ptr=0
        do_reset();                  // cycle 0
        set_v(0, 96'hB0);
        set_v(3, 96'hB3);
        cli_req_ENA = 4'b1001;
        adv();                       // cycle 1
        cli_req_ENA = '0;
        settle();
        chk("t2_c1_issue",   mem_req_ENA, 1'b1);
        chk("t2_c1_payload", mem_req_v,   96'hB0);
        chk("t2_c1_req_rdy", cli_req_RDY, 4'b0110);
        adv();                       // cycle 2
        settle();
        chk("t2_c2_req_rdy", cli_req_RDY, 4'b0111);
        chk("t2_c2_no_issue", mem_req_ENA, 1'b0);
        repeat (3) adv();            // cycle 5
        settle();
        chk("t2_c5_res_rdy", cli_resValue_RDY, 4'b0001);
        chk("t2_c5_no_issue", mem_req_ENA, 1'b0);
        cli_resAccept_ENA = 4'b0001;
        adv();                       // cycle 6
        cli_resAccept_ENA = '0;
        settle();
        chk("t2_c6_issue",   mem_req_ENA, 1'b1);
        chk("t2_c6_payload", mem_req_v,   96'hB3);
        repeat (4) adv();            // cycle 10
        settle();
        chk("t2_c10_res_rdy", cli_resValue_RDY, 4'b1000);
        cli_resAccept_ENA = 4'b1000;
        adv();                       // cycle 11
        cli_resAccept_ENA = '0;

        // Stalled accept by owner 1 with client 2 pending; non-owner accept attempt
        set_v(1, 96'hC1);
        set_v(2, 96'hC2);
        cli_req_ENA = 4'b0110;       // cycle 0
        adv();                       // cycle 1
        cli_req_ENA = '0;
        settle();
        chk("t4_c1_payload", mem_req_v, 96'hC1);
        repeat (4) adv();            // cycle 5
        settle();
        chk("t4_c5_res_rdy", cli_resValue_RDY, 4'b0010);
        chk("t4_c5_no_issue", mem_req_ENA, 1'b0);
        adv();                       // cycle 6
        cli_resAccept_ENA = 4'b0001; // client 0 is not the owner
        settle();
        chk("t5_nonowner_mem_acc", mem_resAccept_ENA, 1'b0);
        chk("t4_c6_res_rdy", cli_resValue_RDY, 4'b0010);
        chk("t4_c6_no_issue", mem_req_ENA, 1'b0);
        adv();                       // cycle 7
        cli_resAccept_ENA = '0;
        settle();
        chk("t5_still_busy_res_rdy", cli_resValue_RDY, 4'b0010);
        chk("t4_c7_no_issue", mem_req_ENA, 1'b0);
        adv();                       // cycle 8
        settle();
        chk("t4_c8_res_rdy", cli_resValue_RDY, 4'b0010);
        chk("t4_c8_no_issue", mem_req_ENA, 1'b0);
        cli_resAccept_ENA = 4'b0010;
        settle();
        chk("t4_c8_mem_acc", mem_resAccept_ENA, 1'b1);
        adv();                       // cycle 9
        cli_resAccept_ENA = '0;
        settle();
        chk("t4_c9_issue",   mem_req_ENA, 1'b1);
        chk("t4_c9_payload", mem_req_v,   96'hC2);
        repeat (4) adv();            // cycle 13
        settle();
        chk("t4_c13_res_rdy", cli_resValue_RDY, 4'b0100);
        cli_resAccept_ENA = 4'b0100;
        adv();                       // cycle 14
        cli_resAccept_ENA = '0;

        // Reset in the middle of a BUSY transaction with two requests pending
        set_v(0, 96'hD0);
        cli_req_ENA = 4'b0001;       // cycle 0
        adv();                       // cycle 1
        set_v(1, 96'hD1);
        set_v(3, 96'hD3);
        cli_req_ENA = 4'b1010;
        settle();
        chk("t6_c1_payload", mem_req_v, 96'hD0);
        adv();                       // cycle 2
        cli_req_ENA = '0;
        settle();
        chk("t6_c2_req_rdy", cli_req_RDY, 4'b0101);
        adv();                       // cycle 3
        nRST = 1'b0;
        adv();                       // cycle 4
        nRST = 1'b1;
        settle();
        chk("t6_rst_req_rdy", cli_req_RDY,      4'hF);
        chk("t6_rst_res_rdy", cli_resValue_RDY, 4'h0);
        chk("t6_rst_no_issue", mem_req_ENA,     1'b0);
        set_v(0, 96'hE0);
        set_v(3, 96'hE3);
        cli_req_ENA = 4'b1001;
        adv();                       // cycle 5
        cli_req_ENA = '0;
        settle();
        chk("t6_post_issue",   mem_req_ENA, 1'b1);
        chk("t6_post_payload", mem_req_v,   96'hE0);

        // Fairness: every client re-requests whenever allowed, accepts immediately
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_v(i, W'(i));
            per_cli[i] = 0;
        end
        grants = 0;
        for (int c = 0; c < 400 && grants < 20; c++) begin
            cli_req_ENA       = cli_req_RDY;
            cli_resAccept_ENA = cli_resValue_RDY;
            settle();
            if (mem_req_ENA) begin
                chk("fair_order", mem_req_v[7:0], 128'(grants % NREQ));
                per_cli[mem_req_v[1:0]]++;
                grants++;
            end
            adv();
        end
        cli_req_ENA       = '0;
        cli_resAccept_ENA = '0;
        chk("fair_total", grants, 20);
        for (int i = 0; i < NREQ; i++) begin
            chk("fair_per_client", per_cli[i], 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lpm_memory_arbiter.md
# lpm_memory_arbiter

Round-robin arbiter that shares one `LpmMemory` instance (a single-outstanding request/response memory with a fixed 4-cycle service delay) between NREQ client requesters. Each client gets a one-entry request buffer. The arbiter issues buffered requests to the memory one at a time, records which client owns the in-flight request, and steers the memory's response ready/accept handshake to that owner only. It sits between the LPM lookup engines and the shared memory.

## Interface
Parameters:
- NREQ, 4, number of clients; 2..8.
- WIDTH, 96, request/response payload width; matches the memory's 96-bit `req`/`resValue`.
- IDXW, $clog2(NREQ), width of client index registers.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous, active-low reset
- cli_req_ENA  in  NREQ  per-client request strobe; asserted only while the matching cli_req_RDY is high
- cli_req_v  in  NREQ*WIDTH  per-client request payload; client i uses bits [i*WIDTH +: WIDTH]
- cli_req_RDY  out  NREQ  client i's request buffer is empty
- cli_resValue  out  WIDTH  response payload, shared by all clients
- cli_resValue_RDY  out  NREQ  response valid for client i
- cli_resAccept_ENA  in  NREQ  client i consumes its response
- cli_resAccept_RDY  out  NREQ  client i may accept now
- mem_req_ENA  out  1  issue a request to the memory
- mem_req_v  out  WIDTH  payload issued to the memory
- mem_req_RDY  in  1  memory is idle
- mem_resValue  in  WIDTH  memory response payload
- mem_resValue_RDY  in  1  memory response valid
- mem_resAccept_ENA  out  1  consume the memory response
- mem_resAccept_RDY  in  1  memory can accept

## Operation
- Registers: pending[NREQ], buf[NREQ] (WIDTH each), state {IDLE, BUSY}, owner (IDXW bits), rr_ptr (IDXW bits).
- Capture: cli_req_ENA[i] sets pending[i] and loads buf[i] <= cli_req_v slice i.
- cli_req_RDY[i] = !pending[i]. There is no bypass: a buffer is never refilled in the same cycle it drains.
- Winner selection: the first i with pending[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
- IDLE issue condition: state=IDLE, some pending bit set, and mem_req_RDY=1. All of the following are combinational:
  - mem_req_ENA=1.
  - mem_req_v = buf[winner].
- IDLE issue register updates:
  - pending[winner] <= 0.
  - owner <= winner.
  - rr_ptr <= (winner+1) mod NREQ.
  - state <= BUSY.
- BUSY response steering:
  - cli_resValue = mem_resValue, always passed through.
  - cli_resValue_RDY[i] = BUSY & owner==i & mem_resValue_RDY.
  - cli_resAccept_RDY[i] = BUSY & owner==i & mem_resAccept_RDY.
  - All non-owner bits are 0.
- BUSY accept:
  - mem_resAccept_ENA = BUSY & cli_resAccept_ENA[owner] & mem_resAccept_RDY.
  - When it fires, state <= IDLE.
- Non-owner cli_resAccept_ENA is ignored. mem_req_ENA is never asserted in BUSY.
- Simultaneous events:
  - Captures into other clients' buffers proceed in the same cycle as an issue or an accept.
  - An accept and a new issue never happen in the same cycle; the issue follows the accept by at least one cycle.
- The IDXW arithmetic for rr_ptr wraps at NREQ. When NREQ is not a power of 2, the wrap is explicit (NREQ-1 goes to 0).

## Timing
- Reset values:
  - pending = 0, buf = 0, state = IDLE, owner = 0, rr_ptr = 0.
  - Outputs: cli_req_RDY all 1; mem_req_ENA 0; cli_resValue_RDY 0; cli_resAccept_RDY 0; mem_resAccept_ENA 0; mem_req_v 0.
- Request latency, with the memory idle: cli_req_ENA at cycle t gives the following.
  - pending at t+1, with mem_req_ENA at t+1.
  - Memory delay count is 4 at t+2 and reaches 1 at t+5.
  - cli_resValue_RDY[owner] is high from t+5.
- Accept at cycle a puts the arbiter in IDLE at a+1. The next issue is at a+1 at the earliest, as soon as mem_req_RDY is seen.
- cli_req_RDY[i] goes high at t+2 after an issue at t+1, and stays low until then.
- A client holding off its accept keeps its RDY bits high indefinitely. No other issue occurs in the meantime.
- Reset asserted mid-BUSY or with buffers pending: every request is dropped and the arbiter returns to the reset values on the next edge. The memory shares nRST and clears in the same cycle.
- mem_req_RDY low in IDLE: requests stay pending. rr_ptr is unchanged.

## Test plan
- Single request: client 2 sends 96'h0000000C_0000000B_0000000A at cycle 0 → mem_req_ENA with that value at cycle 1. cli_resValue_RDY = 4'b0100 at cycle 5. Accept at cycle 5 → cli_req_RDY[2] is back at 1 from cycle 2, and state is IDLE at cycle 6.
- Contention: clients 0 and 3 request in the same cycle, rr_ptr=0 → client 0 is served first and rr_ptr becomes 1. Client 3 issues the cycle after client 0's accept.
- Fairness: all 4 clients re-request immediately whenever RDY allows, over 20 grants → grant order is 0,1,2,3,0,1,…; each client gets exactly 5 grants.
- Stalled accept: owner 1 delays cli_resAccept_ENA by 3 cycles while client 2 is pending → cli_resValue_RDY[1] stays high for 4 cycles. No mem_req_ENA in that window; client 2 issues at accept+1.
- Non-owner accept: client 0 asserts cli_resAccept_ENA while client 1 owns → mem_resAccept_ENA stays 0 and state stays BUSY.
- Reset mid-operation: nRST low at cycle 3 of a BUSY transaction, with 2 requests pending → after reset, all cli_req_RDY are 1, no cli_resValue_RDY, and the next request is served with rr_ptr=0.
